axi_lite_line_fetch: RTL

//  AXI4-Lite read master that fills one cache line by issuing BEATS sequential single-beat reads.

---
 rtl/axi_lite_line_fetch.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axi_lite_line_fetch.sv
// -----------------------------------------------------------------------------
// axi_lite_line_fetch
//   AXI4-Lite read master that fills one cache line. It issues BEATS
//   sequential single-beat reads, with at most one AR/R pair outstanding at a
//   time, and assembles the returned words into a line buffer. When the line
//   is complete (or aborted on an error response) it pulses o_done for one
//   cycle.
//
//   Optional feature macro: AXI_LINE_FETCH_ERR_EN
//     defined   : a non-OKAY R response aborts the fetch. No data is stored for
//                 that beat, and o_done and o_error pulse together.
//     undefined : i_rresp is ignored and o_error is tied low.
//
// Ports
//   i_clk, i_arst  clock and synchronous active-high reset
//   i_req          line fetch request, sampled only while idle
//   i_base_addr    line address; the low log2(line bytes) bits are ignored
//   o_busy         high while the AR/R sequence is in progress
//   o_done         one-cycle completion (or abort) pulse
//   o_error        one-cycle pulse together with o_done on an error abort
//   o_line         line buffer; beat k is at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_arvalid, o_araddr, i_arready           AXI read address channel
//   i_rvalid, i_rdata, i_rresp, o_rready     AXI read data channel
// -----------------------------------------------------------------------------
module axi_lite_line_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  input  logic                          i_req,
  input  logic [ADDR_WIDTH-1:0]         i_base_addr,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [BEATS*DATA_WIDTH-1:0]   o_line,
  output logic                          o_arvalid,
  output logic [ADDR_WIDTH-1:0]         o_araddr,
  input  logic                          i_arready,
  input  logic                          i_rvalid,
  input  logic [DATA_WIDTH-1:0]         i_rdata,
  input  logic [1:0]                    i_rresp,
  output logic                          o_rready
);

  localparam int BEAT_W     = $clog2(BEATS);
  localparam int LINE_BYTES = BEATS * DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [BEAT_W-1:0]             r_beat;
  logic [ADDR_WIDTH-1:0]         r_araddr;
  logic [BEATS*DATA_WIDTH-1:0]   r_line;
  logic                          w_r_err;
  logic                          w_r_take;

`ifdef AXI_LINE_FETCH_ERR_EN
  logic r_error;

  assign w_r_err = (i_rresp != 2'b00);

  // The error flag is set on the aborting R handshake. DONE always follows
  // that handshake, so the flag lines up with o_done.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_error <= 1'b0;
    end else begin
      r_error <= (r_state == S_DATA) && i_rvalid && w_r_err;
    end
  end

  assign o_error = r_error;
`else
  logic w_unused_rresp;

  assign w_unused_rresp = ^i_rresp;
  assign w_r_err        = 1'b0;
  assign o_error        = 1'b0;
`endif

  // A beat is stored only on a good R handshake in the DATA state.
  assign w_r_take = (r_state == S_DATA) && i_rvalid && !w_r_err;

  // NOTE: sequential state uses non-blocking assignments, so every flop in this
  // block samples pre-edge values and the order of statements does not matter.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first. Without the
  // defaults, paths that leave a signal unassigned would infer latches.
  always_comb begin
    w_next    = r_state;
    o_busy    = 1'b0;
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    o_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_req) w_next = S_ADDR;
      end
      S_ADDR: begin
        o_busy    = 1'b1;
        o_arvalid = 1'b1;
        if (i_arready) w_next = S_DATA;
      end
      S_DATA: begin
        o_busy   = 1'b1;
        o_rready = 1'b1;
        if (i_rvalid) begin
          w_next = (w_r_err || r_beat == LAST_BEAT) ? S_DONE : S_ADDR;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address, beat count and line buffer.
  // NOTE: the line buffer is a flop array and is reset explicitly. A reset has
  // to leave o_line at zero, so it cannot be treated as a reset-free RAM.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_beat   <= '0;
      r_araddr <= '0;
      r_line   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Track the aligned base every idle cycle. The value captured on
          // the request edge is the one that gets used.
          r_araddr <= i_base_addr & ALIGN_MASK;
          r_beat   <= '0;
        end
        S_DATA: begin
          if (w_r_take) begin
            r_line[r_beat*DATA_WIDTH +: DATA_WIDTH] <= i_rdata;
            r_araddr <= r_araddr + BEAT_BYTES;
            // The last beat leads to DONE, so the counter is held there
            // rather than wrapping.
            if (r_beat != LAST_BEAT) r_beat <= r_beat + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_araddr = r_araddr;
  assign o_line   = r_line;

endmodule
